// File: rtl/custom_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : custom_fifo_pkg
// Brief  : Shared FIFO constants and binary/Gray conversion helpers.
// Rev    : 1.0  initial release
// ============================================================================
package custom_fifo_pkg;

    localparam int DEF_ADDRSIZE = 4;
    localparam int FN_MAXW      = 32;

    function automatic logic [FN_MAXW-1:0] width_mask(input int width);
        return (width >= FN_MAXW) ? '1 : ((FN_MAXW'(1) << width) - FN_MAXW'(1));
    endfunction

    function automatic logic [FN_MAXW-1:0] bin2gray(input logic [FN_MAXW-1:0] bin,
                                                    input int width);
        logic [FN_MAXW-1:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended inputs convert exactly.
    function automatic logic [FN_MAXW-1:0] gray2bin(input logic [FN_MAXW-1:0] gray,
                                                    input int width);
        logic [FN_MAXW-1:0] g;
        logic [FN_MAXW-1:0] b;
        g = gray & width_mask(width);
        b = g;
        for (int i = 1; i < FN_MAXW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/custom_gray2bin.sv
`default_nettype none
// ============================================================================
// Module : custom_gray2bin
// Brief  : Combinational Gray-to-binary converter of parameterizable width.
// Rev    : 1.0  initial release
// ============================================================================
module custom_gray2bin
    import custom_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_ADDRSIZE + 1
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign bin_o = WIDTH'(gray2bin(FN_MAXW'(gray_i), WIDTH));

endmodule
`default_nettype wire

// File: rtl/custom_wptr_full.sv
`default_nettype none
// ============================================================================
// Module : custom_wptr_full
// Brief  : Async-FIFO write pointer with registered full, sticky overflow and
//          optional almost-full (enabled by macro CUSTOM_WPTR_AFULL_EN).
// Rev    : 1.0  initial release
// ============================================================================
module custom_wptr_full
    import custom_fifo_pkg::*;
#(
    parameter int ADDRSIZE     = DEF_ADDRSIZE,
    parameter int AFULL_THRESH = 2
) (
    input  logic                wclk_i,
    input  logic                wrst_n_i,
    input  logic                winc_i,
    input  logic [ADDRSIZE:0]   rptr_sync2_wrclk,
    output logic [ADDRSIZE-1:0] waddr_o,
    output logic [ADDRSIZE:0]   wptr_g,
    output logic                wfull_o,
    output logic                wovf_o
`ifdef CUSTOM_WPTR_AFULL_EN
    ,
    output logic                wafull_o
`endif
);

    localparam int PTR_W = ADDRSIZE + 1;

    if (ADDRSIZE < 2 || AFULL_THRESH < 0 || AFULL_THRESH > (1 << ADDRSIZE)) begin : g_param_chk
        $error("custom_wptr_full: illegal ADDRSIZE/AFULL_THRESH");
    end

    logic [ADDRSIZE:0] wbin_q,  wbin_d;
    logic [ADDRSIZE:0] wgray_q, wgray_d;
    logic              wfull_q, wfull_d;
    logic              wovf_q,  wovf_d;
    logic [ADDRSIZE:0] rptr_full_cmp;

    // A pointer exactly one lap ahead of the read pointer differs in the top two Gray bits.
    assign rptr_full_cmp = {~rptr_sync2_wrclk[ADDRSIZE:ADDRSIZE-1], rptr_sync2_wrclk[ADDRSIZE-2:0]};

    always_comb begin
        wbin_d  = wbin_q + PTR_W'(winc_i & ~wfull_q);
        wgray_d = PTR_W'(bin2gray(FN_MAXW'(wbin_d), PTR_W));
        wfull_d = (wgray_d == rptr_full_cmp);
        wovf_d  = wovf_q | (winc_i & wfull_q);
    end

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            wfull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            wfull_q <= wfull_d;
            wovf_q  <= wovf_d;
        end
    end

    assign waddr_o = wbin_q[ADDRSIZE-1:0];
    assign wptr_g  = wgray_q;
    assign wfull_o = wfull_q;
    assign wovf_o  = wovf_q;

`ifdef CUSTOM_WPTR_AFULL_EN
    localparam logic [ADDRSIZE:0] AFULL_LVL = PTR_W'((1 << ADDRSIZE) - AFULL_THRESH);

    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] used;
    logic              wafull_q, wafull_d;

    custom_gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray_i (rptr_sync2_wrclk),
        .bin_o  (rbin_s)
    );

    always_comb begin
        used     = wbin_d - rbin_s;
        wafull_d = (used >= AFULL_LVL);
    end

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign wafull_o = wafull_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_custom_wptr_full.sv
`default_nettype none
// ============================================================================
// Module : tb_custom_wptr_full
// Brief  : Self-checking bench for custom_wptr_full (ADDRSIZE=4, AFULL_THRESH=2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_custom_wptr_full;

    logic       clk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [4:0] rptr = '0;
    logic [3:0] waddr;
    logic [4:0] wptr_g;
    logic       wfull;
    logic       wovf;
`ifdef CUSTOM_WPTR_AFULL_EN
    logic       wafull;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    custom_wptr_full #(
        .ADDRSIZE     (4),
        .AFULL_THRESH (2)
    ) dut (
        .wclk_i           (clk),
        .wrst_n_i         (wrst_n),
        .winc_i           (winc),
        .rptr_sync2_wrclk (rptr),
        .waddr_o          (waddr),
        .wptr_g           (wptr_g),
        .wfull_o          (wfull),
        .wovf_o           (wovf)
`ifdef CUSTOM_WPTR_AFULL_EN
        ,
        .wafull_o         (wafull)
`endif
    );

    // Reference model: write count modulo 32, occupancy against the read count.
    int m_wc, m_full, m_ovf, m_afull;

    function automatic logic [4:0] gray5(input int v);
        int w;
        w = v & 31;
        return 5'(w ^ (w >> 1));
    endfunction

    function automatic int g2b(input logic [4:0] g);
        int r;
        r = 0;
        for (int v = 0; v < 32; v++) begin
            if (gray5(v) == g) r = v;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_wc = 0; m_full = 0; m_ovf = 0; m_afull = 0;
    endtask

    task automatic model_edge(input logic w, input logic [4:0] rp);
        int used;
        if (w && m_full != 0) m_ovf = 1;
        if (w && m_full == 0) m_wc = (m_wc + 1) % 32;
        used    = (m_wc - g2b(rp) + 32) % 32;
        m_full  = (used == 16) ? 1 : 0;
        m_afull = (used >= 14) ? 1 : 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic [4:0] rp);
        winc = w;
        rptr = rp;
        @(posedge clk);
        model_edge(w, rp);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_waddr"}, int'(waddr),  m_wc % 16);
        chk({tag, "_wptr"},  int'(wptr_g), int'(gray5(m_wc)));
        chk({tag, "_wfull"}, int'(wfull),  m_full);
        chk({tag, "_wovf"},  int'(wovf),   m_ovf);
`ifdef CUSTOM_WPTR_AFULL_EN
        chk({tag, "_wafull"}, int'(wafull), m_afull);
`endif
    endtask

    task automatic cmp_zero(input string tag);
        chk({tag, "_waddr"}, int'(waddr),  0);
        chk({tag, "_wptr"},  int'(wptr_g), 0);
        chk({tag, "_wfull"}, int'(wfull),  0);
        chk({tag, "_wovf"},  int'(wovf),   0);
`ifdef CUSTOM_WPTR_AFULL_EN
        chk({tag, "_wafull"}, int'(wafull), 0);
`endif
    endtask

    // Assert reset between edges, check outputs clear with no edge, release on a negedge.
    task automatic do_reset(input string tag);
        #2;
        wrst_n = 1'b0;
        #1;
        cmp_zero(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        wrst_n = 1'b1;
    endtask

    typedef struct {
        logic       winc;
        logic [4:0] rptr;
        logic [3:0] addr;
        logic [4:0] gray;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t tbl[20];

    initial begin : main
        logic [4:0] hist[$];
        logic [4:0] prev_g;
        int         zero_cnt;
        int         pop;
        int         rc;
        logic       w;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1'b1, 5'b00000, 4'((i + 1) % 16), gray5(i + 1), (i == 15), 1'b0};
        end
        tbl[16] = '{1'b1, 5'b00000, 4'd0, 5'b11000, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 5'b00001, 4'd0, 5'b11000, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 5'b00001, 4'd1, 5'b11001, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 5'b00011, 4'd1, 5'b11001, 1'b0, 1'b1};

        model_reset();
        #2;
        cmp_zero("rst0");
        @(negedge clk);
        wrst_n = 1'b1;

        // Fill, overflow, drain release, refill.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].winc, tbl[i].rptr);
            chk($sformatf("tbl%0d_waddr", i), int'(waddr),  int'(tbl[i].addr));
            chk($sformatf("tbl%0d_wptr", i),  int'(wptr_g), int'(tbl[i].gray));
            chk($sformatf("tbl%0d_wfull", i), int'(wfull),  int'(tbl[i].full));
            chk($sformatf("tbl%0d_wovf", i),  int'(wovf),   int'(tbl[i].ovf));
        end

        // Async reset mid-write: the in-flight write is discarded.
        winc = 1'b1;
        do_reset("rst_mid");
        step(1'b1, 5'b00000);
        chk("post_rst_wptr", int'(wptr_g), 1);
        cmp_model("post_rst");

        // Randomized traffic against the model; reader advances only when data exists.
        rc = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) < 3 && ((m_wc - rc + 32) % 32) != 0) rc = (rc + 1) % 32;
            w = ($urandom_range(9) < 7);
            step(w, gray5(rc));
            cmp_model("rand");
        end

        // Wrap: reader two edges behind, never full, pointer passes 0 twice.
        do_reset("rst_wrap");
        hist = '{5'b00000, 5'b00000};
        prev_g = 5'b00000;
        zero_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, hist.pop_front());
            hist.push_back(gray5(m_wc));
            cmp_model("wrap");
            pop = $countones(prev_g ^ wptr_g);
            chk("wrap_gray_step", pop, 1);
            if (wptr_g == 5'b00000) zero_cnt++;
            prev_g = wptr_g;
        end
        chk("wrap_zero_count", zero_cnt, 2);

`ifdef CUSTOM_WPTR_AFULL_EN
        do_reset("rst_af");
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 5'b00000);
            cmp_model("afull");
            if (i == 13) chk("afull_edge13", int'(wafull), 0);
            if (i == 14) chk("afull_edge14", int'(wafull), 1);
        end
`endif

        winc = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
